// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide memory port arbiter: FSM states,
// access size codes, the IO space base and small byte-lane helpers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    // Byte count of an access; the illegal code 3 behaves like a word.
    function automatic logic [2:0] sizeToLen(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            SZ_B:    len = 3'd1;
            SZ_H:    len = 3'd2;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

    // Replace byte lane idx of word with b.
    function automatic logic [31:0] putByte(input logic [31:0] word,
                                            input logic [1:0]  idx,
                                            input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    // Extract byte lane idx of word.
    function automatic logic [7:0] getByte(input logic [31:0] word,
                                           input logic [1:0]  idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter for the single byte-wide RAM/IO port shared by instruction fetch
// and the load/store unit. Multi-byte accesses are sequenced one byte per
// cycle and answered with a one-cycle done pulse.
// Build option: define MEM_IO_STALL_EN to hold store bytes aimed at IO space
// (address >= IO_BASE) while io_buffer_full is high.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic        flush,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic        isIf_q, isIf_d;
    logic        lastGrant_q, lastGrant_d;
    logic [31:0] memA_q, memA_d;
    logic [7:0]  memDout_q, memDout_d;
    logic        memWr_q, memWr_d;
    logic        ifDone_q, ifDone_d;
    logic        lsDone_q, lsDone_d;
    logic [31:0] ifData_q, ifData_d;
    logic [31:0] lsRdata_q, lsRdata_d;

    logic        ifOk, lsOk;
    logic        grantIf, grantLs;
    logic        lastByte;
    logic        ioStall;
    logic [31:0] nextAddr;
    logic [31:0] captured;
    logic [7:0]  nextByte;

    // A requester is eligible only if its previous done is not still showing
    // and no branch flush is in progress.
    assign ifOk = if_req && !ifDone_q && !flush;
    assign lsOk = ls_req && !lsDone_q && !flush;

    assign lastByte = (cnt_q == (len_q - 3'd1));
    assign nextAddr = addr_q + {29'd0, cnt_q} + 32'd1;
    assign captured = putByte(buf_q, cnt_q[1:0], mem_din);
    assign nextByte = getByte(wdata_q, cnt_q[1:0] + 2'd1);

`ifdef MEM_IO_STALL_EN
    assign ioStall = (state_q == ST_WRITE) && (memA_q >= IO_BASE) && io_buffer_full;
`else
    logic unusedIoInputs;
    assign ioStall = 1'b0;
    assign unusedIoInputs = io_buffer_full ^ (memA_q >= IO_BASE);
`endif

    assign mem_a    = memA_q;
    assign mem_dout = memDout_q;
    assign mem_wr   = memWr_q && rdy && !ioStall;
    assign if_done  = ifDone_q;
    assign if_data  = ifData_q;
    assign ls_done  = lsDone_q;
    assign ls_rdata = lsRdata_q;

    // State register: everything holds while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            isIf_q      <= 1'b0;
            lastGrant_q <= GRANT_IF;
            memA_q      <= 32'd0;
            memDout_q   <= 8'd0;
            memWr_q     <= 1'b0;
            ifDone_q    <= 1'b0;
            lsDone_q    <= 1'b0;
            ifData_q    <= 32'd0;
            lsRdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            isIf_q      <= isIf_d;
            lastGrant_q <= lastGrant_d;
            memA_q      <= memA_d;
            memDout_q   <= memDout_d;
            memWr_q     <= memWr_d;
            ifDone_q    <= ifDone_d;
            lsDone_q    <= lsDone_d;
            ifData_q    <= ifData_d;
            lsRdata_q   <= lsRdata_d;
        end
    end

    // Next state: round-robin grant in IDLE, then one byte per cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        isIf_d      = isIf_q;
        lastGrant_d = lastGrant_q;
        memA_d      = memA_q;
        memDout_d   = memDout_q;
        memWr_d     = memWr_q;
        ifDone_d    = ifDone_q;
        lsDone_d    = lsDone_q;
        ifData_d    = ifData_q;
        lsRdata_d   = lsRdata_q;
        grantIf     = 1'b0;
        grantLs     = 1'b0;

        if (rdy) begin
            ifDone_d = 1'b0;
            lsDone_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    memWr_d = 1'b0;
                    if (lsOk && (!ifOk || lastGrant_q == GRANT_IF)) begin
                        grantLs = 1'b1;
                    end else if (ifOk) begin
                        grantIf = 1'b1;
                    end
                    if (grantLs) begin
                        lastGrant_d = GRANT_LS;
                        isIf_d      = 1'b0;
                        addr_d      = ls_addr;
                        wdata_d     = ls_wdata;
                        len_d       = sizeToLen(ls_size);
                        cnt_d       = 3'd0;
                        buf_d       = 32'd0;
                        memA_d      = ls_addr;
                        if (ls_we) begin
                            state_d   = ST_WRITE;
                            memWr_d   = 1'b1;
                            memDout_d = ls_wdata[7:0];
                        end else begin
                            state_d = ST_READ;
                        end
                    end else if (grantIf) begin
                        lastGrant_d = GRANT_IF;
                        isIf_d      = 1'b1;
                        addr_d      = if_addr;
                        len_d       = 3'd4;
                        cnt_d       = 3'd0;
                        buf_d       = 32'd0;
                        memA_d      = if_addr;
                        state_d     = ST_READ;
                    end
                end
                ST_READ: begin
                    memWr_d = 1'b0;
                    if (flush) begin
                        state_d = ST_IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        buf_d  = captured;
                        memA_d = nextAddr;
                        if (lastByte) begin
                            state_d = ST_IDLE;
                            cnt_d   = 3'd0;
                            if (isIf_q) begin
                                ifDone_d = 1'b1;
                                ifData_d = captured;
                            end else begin
                                lsDone_d  = 1'b1;
                                lsRdata_d = captured;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!ioStall) begin
                        if (lastByte) begin
                            memWr_d  = 1'b0;
                            lsDone_d = 1'b1;
                            state_d  = ST_IDLE;
                            cnt_d    = 3'd0;
                        end else begin
                            cnt_d     = cnt_q + 3'd1;
                            memA_d    = nextAddr;
                            memDout_d = nextByte;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    memWr_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. A small byte RAM answers
// reads combinationally from the registered mem_a and records writes.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        flush;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  ram [0:65535];
    int          compared = 0;
    int          mismatched = 0;
    int          cycles;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_we          (ls_we),
        .ls_size        (ls_size),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata),
        .flush          (flush),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[15:0]];

    // RAM write port
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                 input logic lReq, input logic we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if_req   = iReq;
        if_addr  = iAddr;
        ls_req   = lReq;
        ls_we    = we;
        ls_size  = size;
        ls_addr  = addr;
        ls_wdata = wdata;
    endtask

    // Tick until the selected done is seen, bounded by limit.
    task automatic waitDone(input bit forLs, input int limit, output int n);
        logic d;
        n = 0;
        do begin
            tick();
            n++;
            d = forLs ? ls_done : if_done;
        end while (d !== 1'b1 && n < limit);
        checkOutput(forLs ? "ls_done_seen" : "if_done_seen", {31'd0, d}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13;
        ram[16'h0101] = 8'h05;
        ram[16'h0200] = 8'h11;
        ram[16'h0203] = 8'h44;
        ram[16'hFFFF] = 8'h5A;
        ram[16'h0000] = 8'hA5;

        rst = 1'b1;
        rdy = 1'b1;
        flush = 1'b0;
        io_buffer_full = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_mem_a", mem_a, 32'd0);
        checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("rst_if_done", {31'd0, if_done}, 32'd0);
        checkOutput("rst_ls_done", {31'd0, ls_done}, 32'd0);
        checkOutput("rst_if_data", if_data, 32'd0);
        checkOutput("rst_ls_rdata", ls_rdata, 32'd0);

        // Word fetch from 0x100: address walk then done on the fourth edge
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        tick();
        checkOutput("fetch_a0", mem_a, 32'h100);
        for (int k = 1; k < 4; k++) begin
            tick();
            checkOutput("fetch_a", mem_a, 32'h100 + k);
            checkOutput("fetch_early_done", {31'd0, if_done}, 32'd0);
        end
        tick();
        checkOutput("fetch_done", {31'd0, if_done}, 32'd1);
        checkOutput("fetch_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        tick();
        checkOutput("fetch_done_pulse", {31'd0, if_done}, 32'd0);

        // Half store of 0xAABBCCDD at 0x201
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 2'd1, 32'h201, 32'hAABB_CCDD);
        tick();
        checkOutput("st_wr0", {31'd0, mem_wr}, 32'd1);
        checkOutput("st_a0", mem_a, 32'h201);
        checkOutput("st_d0", {24'd0, mem_dout}, 32'hDD);
        tick();
        checkOutput("st_wr1", {31'd0, mem_wr}, 32'd1);
        checkOutput("st_a1", mem_a, 32'h202);
        checkOutput("st_d1", {24'd0, mem_dout}, 32'hCC);
        tick();
        checkOutput("st_wr_end", {31'd0, mem_wr}, 32'd0);
        checkOutput("st_done", {31'd0, ls_done}, 32'd1);
        ls_req = 1'b0;
        checkOutput("st_ram", {16'd0, ram[16'h0202], ram[16'h0201]}, 32'h0000_CCDD);
        tick();

        // Byte load of 0x202
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 32'h202, 32'd0);
        tick();
        checkOutput("ldb_a0", mem_a, 32'h202);
        waitDone(1'b1, 10, cycles);
        checkOutput("ldb_cycles", cycles, 32'd1);
        checkOutput("ldb_data", ls_rdata, 32'h0000_00CC);
        ls_req = 1'b0;
        tick();

        // Contention: last grant was ls, so fetch goes first, then they alternate
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 2'd2, 32'h200, 32'd0);
        tick();
        for (int g = 0; g < 4; g++) begin
            checkOutput("cont_grant", mem_a, (g % 2 == 0) ? 32'h100 : 32'h200);
            waitDone(g % 2 == 1, 10, cycles);
            checkOutput("cont_cycles", cycles, 32'd4);
            if (g % 2 == 0) begin
                checkOutput("cont_if_data", if_data, 32'h0000_0513);
                checkOutput("cont_ls_quiet", {31'd0, ls_done}, 32'd0);
                if_req = 1'b0;
            end else begin
                checkOutput("cont_ls_data", ls_rdata, 32'h44CC_DD11);
                checkOutput("cont_if_quiet", {31'd0, if_done}, 32'd0);
                ls_req = 1'b0;
            end
            tick();
            checkOutput("cont_pulse", {30'd0, if_done, ls_done}, 32'd0);
            if (g < 2) begin
                if (g % 2 == 0) if_req = 1'b1;
                else ls_req = 1'b1;
            end
        end

        // Flush a fetch at cnt = 2; keep flush a second cycle to block re-accept
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        checkOutput("flush_no_done", {31'd0, if_done}, 32'd0);
        checkOutput("flush_a_hold", mem_a, 32'h102);
        tick();
        checkOutput("flush_blocks_accept", mem_a, 32'h102);
        checkOutput("flush_no_done2", {31'd0, if_done}, 32'd0);
        flush = 1'b0;
        if_req = 1'b0;
        tick();
        checkOutput("flush_no_done3", {31'd0, if_done}, 32'd0);

        // Last grant was fetch, so with both asking the word store wins;
        // a flush during the store is ignored
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 2'd2, 32'h210, 32'h0403_0201);
        tick();
        checkOutput("rr_store_wins", {31'd0, mem_wr}, 32'd1);
        checkOutput("fst_a0", mem_a, 32'h210);
        checkOutput("fst_d0", {24'd0, mem_dout}, 32'h01);
        flush = 1'b1;
        tick();
        checkOutput("fst_d1", {24'd0, mem_dout}, 32'h02);
        checkOutput("fst_wr1", {31'd0, mem_wr}, 32'd1);
        flush = 1'b0;
        tick();
        checkOutput("fst_d2", {24'd0, mem_dout}, 32'h03);
        tick();
        checkOutput("fst_d3", {24'd0, mem_dout}, 32'h04);
        checkOutput("fst_a3", mem_a, 32'h213);
        tick();
        checkOutput("fst_done", {31'd0, ls_done}, 32'd1);
        checkOutput("fst_wr_end", {31'd0, mem_wr}, 32'd0);
        ls_req = 1'b0;
        checkOutput("fst_ram", {ram[16'h0213], ram[16'h0212], ram[16'h0211], ram[16'h0210]}, 32'h0403_0201);
        tick();
        checkOutput("pending_fetch_a", mem_a, 32'h100);
        waitDone(1'b0, 10, cycles);
        checkOutput("pending_fetch_cycles", cycles, 32'd4);
        checkOutput("pending_fetch_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        tick();

        // rdy low for 3 cycles in the middle of a word load
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2'd2, 32'h210, 32'd0);
        tick();
        tick();
        checkOutput("rdy_a1", mem_a, 32'h211);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("rdy_a_frozen", mem_a, 32'h211);
            checkOutput("rdy_no_done", {31'd0, ls_done}, 32'd0);
        end
        rdy = 1'b1;
        waitDone(1'b1, 10, cycles);
        checkOutput("rdy_resume_cycles", cycles, 32'd3);
        checkOutput("rdy_data", ls_rdata, 32'h0403_0201);
        rdy = 1'b0;
        ls_req = 1'b0;
        tick();
        checkOutput("rdy_done_holds", {31'd0, ls_done}, 32'd1);
        rdy = 1'b1;
        tick();
        checkOutput("rdy_done_clears", {31'd0, ls_done}, 32'd0);

        // Half load across the top of the address space wraps to 0
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0);
        tick();
        checkOutput("wrap_a0", mem_a, 32'hFFFF_FFFF);
        tick();
        checkOutput("wrap_a1", mem_a, 32'h0000_0000);
        checkOutput("wrap_early", {31'd0, ls_done}, 32'd0);
        tick();
        checkOutput("wrap_done", {31'd0, ls_done}, 32'd1);
        checkOutput("wrap_data", ls_rdata, 32'h0000_A55A);
        ls_req = 1'b0;
        tick();

        // Illegal size code 3 acts as a word
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2'd3, 32'h100, 32'd0);
        tick();
        waitDone(1'b1, 10, cycles);
        checkOutput("sz3_cycles", cycles, 32'd4);
        checkOutput("sz3_data", ls_rdata, 32'h0000_0513);
        ls_req = 1'b0;
        tick();

        // Byte store into IO space with the IO buffer full
        io_buffer_full = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
`ifdef MEM_IO_STALL_EN
        tick();
        checkOutput("io_a", mem_a, 32'h0003_0000);
        checkOutput("io_wr_stalled", {31'd0, mem_wr}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("io_wr_stalled", {31'd0, mem_wr}, 32'd0);
            checkOutput("io_no_done", {31'd0, ls_done}, 32'd0);
            checkOutput("io_a_hold", mem_a, 32'h0003_0000);
        end
        io_buffer_full = 1'b0;
        #1;
        checkOutput("io_wr_release", {31'd0, mem_wr}, 32'd1);
        checkOutput("io_dout", {24'd0, mem_dout}, 32'h41);
        tick();
`else
        tick();
        checkOutput("io_wr_ignored_full", {31'd0, mem_wr}, 32'd1);
        checkOutput("io_dout", {24'd0, mem_dout}, 32'h41);
        tick();
`endif
        checkOutput("io_done", {31'd0, ls_done}, 32'd1);
        checkOutput("io_wr_end", {31'd0, mem_wr}, 32'd0);
        checkOutput("io_ram", {24'd0, ram[16'h0000]}, 32'h41);
        ls_req = 1'b0;
        io_buffer_full = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
